scan_sig_compactor: RTL and testbench

//  Sink stage of the BIST-per-scan path. The pattern LFSR drives scan_in into the CUT scan chain;

---
 rtl/scan_sig_compactor_pkg.sv | 30 +++
 rtl/sisr_compactor.sv | 30 +++
 rtl/scan_sig_compactor.sv | 110 +++++++++++
 tb/tb_scan_sig_compactor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_sig_compactor_pkg.sv
// Shared definitions for the scan signature compactor: FSM encoding, default SISR shape
// and the single-step SISR update used by both the register and the pass compare.
package scan_sig_compactor_pkg;

   localparam int unsigned DefSigWidth = 16;
   localparam logic [63:0] DefSigPoly  = 64'h8005;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StShift   = 3'd1,
      StCapture = 3'd2,
      StUnload  = 3'd3,
      StDone    = 3'd4
   } state_e;

   // Works on a 64-bit container so any SIG_WIDTH up to 64 can share it.
   function automatic logic [63:0] sisr_step(input logic [63:0] sig, input logic [63:0] poly,
                                             input int unsigned width, input logic din);
      logic [5:0]  msb;
      logic        fb;
      logic [63:0] nxt;
      logic [63:0] mask;
      msb  = 6'(width - 1);
      fb   = sig[msb] ^ din;
      nxt  = (sig << 1) ^ (fb ? poly : 64'd0);
      mask = (64'd1 << width) - 64'd1;
      return nxt & mask;
   endfunction

endpackage

// File: rtl/sisr_compactor.sv
// Serial-input signature register: folds one scan bit per enabled cycle into the signature.
module sisr_compactor
   import scan_sig_compactor_pkg::*;
#(
   parameter int unsigned          SIG_WIDTH = DefSigWidth,
   parameter logic [SIG_WIDTH-1:0] SIG_POLY  = SIG_WIDTH'(DefSigPoly)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 en,
   input  logic                 din,
   output logic [SIG_WIDTH-1:0] sig
);

   logic [SIG_WIDTH-1:0] sig_next;

   always_comb begin
      sig_next = SIG_WIDTH'(sisr_step(64'(sig), 64'(SIG_POLY), SIG_WIDTH, din));
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         sig <= '0;
      end else if (en) begin
         sig <= sig_next;
      end
   end

endmodule

// File: rtl/scan_sig_compactor.sv
// BIST-per-scan sink: sequences shift/capture on the scan chain, compacts the unloaded
// response into an SISR and reports pass/fail against a golden signature at the end.
module scan_sig_compactor
   import scan_sig_compactor_pkg::*;
#(
   parameter int unsigned          CHAIN_LEN    = 7,
   parameter int unsigned          NUM_PATTERNS = 100,
   parameter int unsigned          SIG_WIDTH    = DefSigWidth,
   parameter logic [SIG_WIDTH-1:0] SIG_POLY     = SIG_WIDTH'(DefSigPoly),
   parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = '0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 scan_out,
   output logic                 scan_enable,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [SIG_WIDTH-1:0] signature,
   output logic [15:0]          pattern_count
);

   localparam int unsigned     CntW    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CHAIN_LEN - 1);
   localparam logic [15:0]     PatLast = 16'(NUM_PATTERNS);

   state_e               state;
   logic [CntW-1:0]      shift_cnt;
   logic                 sig_clear;
   logic                 sig_en;
   logic [SIG_WIDTH-1:0] sig_next;
   logic [15:0]          pat_next;

   always_comb begin
      sig_clear = ((state == StIdle) || (state == StDone)) && start;
      sig_en    = (state == StShift) || (state == StUnload);
      // Signature as it will be after this edge, so pass can be registered on DONE entry.
      sig_next  = SIG_WIDTH'(sisr_step(64'(signature), 64'(SIG_POLY), SIG_WIDTH, scan_out));
      pat_next  = (pattern_count == 16'hFFFF) ? pattern_count : pattern_count + 16'd1;
   end

   sisr_compactor #(
      .SIG_WIDTH (SIG_WIDTH),
      .SIG_POLY  (SIG_POLY)
   ) u_sisr (
      .clock (clock),
      .reset (reset),
      .clear (sig_clear),
      .en    (sig_en),
      .din   (scan_out),
      .sig   (signature)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= StIdle;
         shift_cnt     <= '0;
         pattern_count <= '0;
         scan_enable   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state         <= StShift;
                  shift_cnt     <= '0;
                  pattern_count <= '0;
                  scan_enable   <= 1'b1;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  pass          <= 1'b0;
               end
            end
            StShift: begin
               if (shift_cnt == CntLast) begin
                  shift_cnt   <= '0;
                  state       <= StCapture;
                  scan_enable <= 1'b0;
               end else begin
                  shift_cnt <= shift_cnt + CntW'(1);
               end
            end
            StCapture: begin
               pattern_count <= pat_next;
               scan_enable   <= 1'b1;
               state         <= (pat_next == PatLast) ? StUnload : StShift;
            end
            StUnload: begin
               if (shift_cnt == CntLast) begin
                  shift_cnt   <= '0;
                  state       <= StDone;
                  scan_enable <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  pass        <= (sig_next == GOLDEN_SIG);
               end else begin
                  shift_cnt <= shift_cnt + CntW'(1);
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_sig_compactor.sv
// Bench for scan_sig_compactor: a cycle-indexed run model checked every cycle against three
// instances, plus directed runs with literal expectations.
module tb_scan_sig_compactor;

   localparam int CL = 7;
   localparam int NP = 4;

   typedef struct packed {
      bit          run;
      int          k;
      logic [15:0] sig;
      logic [15:0] cnt;
      bit          done;
      bit          pass;
      bit          se;
      bit          busy;
   } mdl_t;

   function automatic logic [15:0] sig_step(input logic [15:0] s, input logic d);
      logic fb;
      fb = s[15] ^ d;
      return {s[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
   endfunction

   // Final signature of a run where scan_out is 1 only on the first shift cycle.
   function automatic logic [15:0] gold_stream2();
      logic [15:0] s;
      s = 16'h0;
      for (int i = 0; i < (NP + 1) * CL; i++) s = sig_step(s, (i == 0));
      return s;
   endfunction

   localparam logic [15:0] GoldB = gold_stream2();

   // k = cycle number since start was accepted; phase follows from arithmetic on k.
   function automatic mdl_t mstep(input mdl_t m, input int cl, input int np,
                                  input logic [15:0] gold, input logic rst, input logic st,
                                  input logic din);
      mdl_t n;
      int   last_cap;
      int   done_k;
      n        = m;
      last_cap = np * (cl + 1);
      done_k   = last_cap + cl + 1;
      if (rst) begin
         n = '0;
      end else if (!m.run) begin
         if (st) begin
            n.run = 1; n.k = 1; n.sig = 0; n.cnt = 0;
            n.done = 0; n.pass = 0; n.busy = 1; n.se = 1;
         end
      end else begin
         if (m.k <= last_cap && ((m.k - 1) % (cl + 1)) == cl) begin
            if (m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
         end else begin
            n.sig = sig_step(m.sig, din);
         end
         n.k = m.k + 1;
         if (n.k == done_k) begin
            n.run = 0; n.done = 1; n.busy = 0; n.se = 0;
            n.pass = (n.sig == gold);
         end else begin
            n.se = !(n.k <= last_cap && ((n.k - 1) % (cl + 1)) == cl);
         end
      end
      return n;
   endfunction

   logic        clock = 1'b0;
   logic        reset, start, start_c, scan_out;
   logic        a_se, a_busy, a_done, a_pass;
   logic        b_se, b_busy, b_done, b_pass;
   logic        c_se, c_busy, c_done, c_pass;
   logic [15:0] a_sig, a_cnt, b_sig, b_cnt, c_sig, c_cnt;

   int   errors = 0;
   int   checks = 0;
   bit   chk_en = 0;
   int   c = 0;
   mdl_t ma = '0, mb = '0, mc = '0;

   always #5 clock = ~clock;

   scan_sig_compactor #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP), .SIG_WIDTH(16),
                        .SIG_POLY(16'h8005), .GOLDEN_SIG(16'h0000)) dut_a (
      .clock(clock), .reset(reset), .start(start), .scan_out(scan_out),
      .scan_enable(a_se), .busy(a_busy), .done(a_done), .pass(a_pass),
      .signature(a_sig), .pattern_count(a_cnt));

   scan_sig_compactor #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP), .SIG_WIDTH(16),
                        .SIG_POLY(16'h8005), .GOLDEN_SIG(GoldB)) dut_b (
      .clock(clock), .reset(reset), .start(start), .scan_out(scan_out),
      .scan_enable(b_se), .busy(b_busy), .done(b_done), .pass(b_pass),
      .signature(b_sig), .pattern_count(b_cnt));

   scan_sig_compactor #(.CHAIN_LEN(2), .NUM_PATTERNS(1), .SIG_WIDTH(16),
                        .SIG_POLY(16'h8005), .GOLDEN_SIG(16'h0000)) dut_c (
      .clock(clock), .reset(reset), .start(start_c), .scan_out(scan_out),
      .scan_enable(c_se), .busy(c_busy), .done(c_done), .pass(c_pass),
      .signature(c_sig), .pattern_count(c_cnt));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cmp(input string nm, input mdl_t m, input logic se, input logic bsy,
                      input logic dn, input logic ps, input logic [15:0] sg,
                      input logic [15:0] cn);
      check({nm, ".scan_enable"}, 32'(se), 32'(m.se));
      check({nm, ".busy"}, 32'(bsy), 32'(m.busy));
      check({nm, ".done"}, 32'(dn), 32'(m.done));
      check({nm, ".pass"}, 32'(ps), 32'(m.pass));
      check({nm, ".signature"}, 32'(sg), 32'(m.sig));
      check({nm, ".pattern_count"}, 32'(cn), 32'(m.cnt));
   endtask

   // Inputs change only at posedge+2, so values seen here are what the next edge samples.
   initial begin
      forever begin
         @(negedge clock);
         if (chk_en) begin
            cmp("a", ma, a_se, a_busy, a_done, a_pass, a_sig, a_cnt);
            cmp("b", mb, b_se, b_busy, b_done, b_pass, b_sig, b_cnt);
            cmp("c", mc, c_se, c_busy, c_done, c_pass, c_sig, c_cnt);
         end
         ma = mstep(ma, CL, NP, 16'h0000, reset, start, scan_out);
         mb = mstep(mb, CL, NP, GoldB, reset, start, scan_out);
         mc = mstep(mc, 2, 1, 16'h0000, reset, start_c, scan_out);
      end
   end

   task automatic step();
      @(posedge clock);
      #2;
      c++;
   endtask

   // One run on dut_a/dut_b; scan_out=1 on cycle 1 if one, and on cycle flip.
   task automatic run_ab(input bit one, input int flip, output int done_cyc);
      int se_ones;
      se_ones  = 0;
      done_cyc = -1;
      start    = 1'b1;
      scan_out = 1'b0;
      c        = 0;
      step();
      start = 1'b0;
      while (done_cyc < 0 && c < 200) begin
         scan_out = (one && c == 1) || (c == flip);
         if (a_se) se_ones++;
         step();
         if (one && c == 2) check("sig_after_cycle1", 32'(a_sig), 32'h8005);
         if (one && c == 3) check("sig_after_cycle2", 32'(a_sig), 32'h800F);
         if (one && c == 5) check("sig_after_cycle4", 32'(a_sig), 32'h8033);
         if (a_done) done_cyc = c;
      end
      scan_out = 1'b0;
      check("shift_cycles_per_run", 32'(se_ones), 32'd35);
   endtask

   initial begin
      int dc;
      int ndone;
      logic [4:0] se_vec;
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      int ndone;
      logic [4:0] se_vec;
      reset = 1'b1; start = 1'b0; start_c = 1'b0; scan_out = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      reset  = 1'b0;
      chk_en = 1;
      check("reset_done", 32'(a_done), 32'd0);
      check("reset_sig", 32'(a_sig), 32'd0);
      check("reset_se", 32'(a_se), 32'd0);
      check("reset_cnt", 32'(a_cnt), 32'd0);

      // All-zero response: signature stays zero and matches the zero golden.
      run_ab(0, -1, dc);
      check("t1_done_cycle", 32'(dc), 32'd40);
      check("t1_pass", 32'(a_pass), 32'd1);
      check("t1_sig", 32'(a_sig), 32'd0);
      check("t1_cnt", 32'(a_cnt), 32'd4);
      check("t1_busy", 32'(a_busy), 32'd0);
      repeat (2) step();

      // Single 1 on the first shift; dut_b holds that run's signature as golden.
      run_ab(1, -1, dc);
      check("t2_done_cycle", 32'(dc), 32'd40);
      check("t2_sig_nonzero", 32'(a_sig != 16'h0), 32'd1);
      check("t2_a_pass", 32'(a_pass), 32'd0);
      check("t3_b_pass", 32'(b_pass), 32'd1);
      repeat (2) step();

      run_ab(1, 18, dc);
      check("t3_flip_b_pass", 32'(b_pass), 32'd0);
      check("t3_flip_a_pass", 32'(a_pass), 32'd0);
      repeat (2) step();

      // Abort mid-run with reset at cycle 20.
      start = 1'b1; scan_out = 1'b1; c = 0;
      step();
      start = 1'b0;
      while (c < 20) step();
      reset = 1'b1;
      step();
      reset = 1'b0; scan_out = 1'b0;
      check("t4_se", 32'(a_se), 32'd0);
      check("t4_busy", 32'(a_busy), 32'd0);
      check("t4_done", 32'(a_done), 32'd0);
      check("t4_pass", 32'(a_pass), 32'd0);
      check("t4_sig", 32'(a_sig), 32'd0);
      check("t4_cnt", 32'(a_cnt), 32'd0);
      step();
      run_ab(0, -1, dc);
      check("t4_rerun_done_cycle", 32'(dc), 32'd40);
      check("t4_rerun_pass", 32'(a_pass), 32'd1);
      check("t4_rerun_cnt", 32'(a_cnt), 32'd4);
      repeat (2) step();

      // start held high: ignored while busy, restarts right after DONE.
      start = 1'b1; c = 0;
      step();
      while (!a_done && c < 200) step();
      check("t5_first_done_cycle", 32'(c), 32'd40);
      step();
      check("t5_done_drop", 32'(a_done), 32'd0);
      check("t5_restart_busy", 32'(a_busy), 32'd1);
      ndone = 0;
      while (c < 81) begin
         step();
         if (a_done) ndone++;
      end
      check("t5_done_width", 32'(ndone), 32'd1);
      start = 1'b0;
      while (!a_done && c < 300) step();
      repeat (3) step();
      check("t5_done_level", 32'(a_done), 32'd1);
      check("t5_cnt_held", 32'(a_cnt), 32'd4);
      step();

      // Short configuration on dut_c.
      start_c = 1'b1; c = 0; se_vec = '0;
      step();
      start_c = 1'b0;
      while (!c_done && c < 50) begin
         if (c <= 5) se_vec = {se_vec[3:0], c_se};
         step();
      end
      check("t6_se_seq", 32'(se_vec), 32'b11011);
      check("t6_done_cycle", 32'(c), 32'd6);
      check("t6_pass", 32'(c_pass), 32'd1);
      check("t6_cnt", 32'(c_cnt), 32'd1);
      repeat (2) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
